// File: rtl/qfix_pkg.sv
// Shared fixed-point definitions for the calculator datapath: default word
// format (total width / fractional bits) and the divider state encoding.
package qfix_pkg;

    localparam int QFIX_N = 32;
    localparam int QFIX_Q = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } qdiv_state_e;

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift the next numerator bit into the
// remainder, subtract the divisor when it fits, and report the quotient bit.
module qdiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic [N-2:0] dvs,
    input  logic         num_bit,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Trial subtraction on the widened remainder; a clear borrow (or a set
    // top bit, which can only exceed the divisor) means the divisor fits.
    always_comb begin
        shifted  = {rem, num_bit};
        diff     = shifted - {2'b00, dvs};
        q_bit    = shifted[N] | ~diff[N];
        rem_next = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/qdiv.sv
// Sequential sign-magnitude fixed-point divider. Restoring long division,
// one quotient bit per clock, with quotient saturation and divide-by-zero flag.
module qdiv
    import qfix_pkg::*;
#(
    parameter int N = QFIX_N,
    parameter int Q = QFIX_Q
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovr,
    output logic         o_div0
);

    // Full quotient width: N-1 integer+fraction magnitude bits plus Q extra
    // bits gained by pre-shifting the numerator.
    localparam int NW = N - 1 + Q;
    localparam int CW = $clog2(NW + 1);

    qdiv_state_e  state;
    logic [N-2:0] dvd_mag;
    logic [N-2:0] dvs_mag;
    logic         sgn;
    logic [NW-1:0] num;
    logic [N-1:0] rem;
    logic [NW-2:0] quo;
    logic [CW-1:0] cnt;

    logic [N-1:0] step_rem;
    logic         step_bit;
    logic [N-1:0] step_rem_nxt;
    logic         step_q;

    logic [NW-1:0] full_q;
    logic          over;
    logic [N-2:0]  mag;

    // The LOAD cycle already performs the first step (remainder 0, numerator
    // MSB = dividend magnitude MSB), so RUN only needs the remaining NW-1.
    always_comb begin
        step_rem = rem;
        step_bit = num[NW-1];
        if (state == ST_LOAD) begin
            step_rem = '0;
            step_bit = dvd_mag[N-2];
        end
    end

    qdiv_step #(.N(N)) u_step (
        .rem      (step_rem),
        .dvs      (dvs_mag),
        .num_bit  (step_bit),
        .rem_next (step_rem_nxt),
        .q_bit    (step_q)
    );

    // Final quotient as seen on the last step: saturate if anything lands
    // above the representable magnitude, otherwise truncate toward zero.
    always_comb begin
        full_q = {quo, step_q};
        over   = |full_q[NW-1:N-1];
        mag    = over ? {(N-1){1'b1}} : full_q[N-2:0];
    end

    assign o_busy = (state == ST_LOAD) || (state == ST_RUN);
    assign o_done = (state == ST_DONE);

    // Control FSM, division datapath and held result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            dvd_mag    <= '0;
            dvs_mag    <= '0;
            sgn        <= 1'b0;
            num        <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            o_quotient <= '0;
            o_ovr      <= 1'b0;
            o_div0     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        dvd_mag <= i_dividend[N-2:0];
                        dvs_mag <= i_divisor[N-2:0];
                        sgn     <= i_dividend[N-1] ^ i_divisor[N-1];
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (dvs_mag == '0) begin
                        o_quotient <= {sgn, {(N-1){1'b1}}};
                        o_ovr      <= 1'b1;
                        o_div0     <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        rem   <= step_rem_nxt;
                        num   <= {dvd_mag[N-3:0], {(Q+1){1'b0}}};
                        quo   <= {{(NW-2){1'b0}}, step_q};
                        cnt   <= CW'(NW - 1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem <= step_rem_nxt;
                    num <= {num[NW-2:0], 1'b0};
                    quo <= {quo[NW-3:0], step_q};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        o_quotient <= {sgn & (mag != '0), mag};
                        o_ovr      <= over;
                        o_div0     <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/qdiv.md
# qdiv

Sequential sign-magnitude fixed-point divider for the fixed-point calculator datapath; it is the inverse of the combinational fixed-point multiplier and uses the same (N, Q) number format. Restoring long division produces one quotient bit per clock behind a start/done handshake. Quotient magnitude saturates on overflow, and divide-by-zero is flagged. The calculator control FSM issues one division at a time and samples the result on `o_done`.

## Interface
- `Q`, 15: fractional bits.
- `N`, 32: total word width; bit N-1 is sign, bits N-2:0 are unsigned magnitude.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_dividend`  in  N  sign-magnitude numerator; sampled with an accepted start.
- `i_divisor`  in  N  sign-magnitude denominator; sampled with an accepted start.
- `o_quotient`  out  N  sign-magnitude result; held from DONE until the next accepted start.
- `o_busy`  out  1  high in LOAD and RUN.
- `o_done`  out  1  single-cycle pulse in DONE.
- `o_ovr`  out  1  result saturated (overflow or divide-by-zero); held with `o_quotient`.
- `o_div0`  out  1  divisor magnitude was zero; held with `o_quotient`.

## Operation
- **Reset values.** All outputs 0. State IDLE. Internal registers 0.
- **States.** IDLE, LOAD, RUN, DONE.
- **IDLE.** `i_start`=1 at an edge latches operands and goes to LOAD. `i_start` is ignored in every other state.
- **LOAD.** Checks the divisor magnitude.
  - Zero divisor: go to DONE with `o_div0`=1, `o_ovr`=1, magnitude all ones, sign = XOR of the input signs.
  - Otherwise: load numerator = dividend magnitude << Q (width N-1+Q), remainder = 0 (width N), iteration counter = N-1+Q, then go to RUN.
- **RUN.** One restoring step per cycle, MSB first:
  - rem' = {rem, next numerator bit}.
  - If rem' >= divisor magnitude, subtract and shift 1 into the quotient; otherwise shift 0.
  - Counter decrements each step. Go to DONE after the step where the counter reaches 0, i.e. after exactly N-1+Q steps.
- **Result formation** (registered on entry to DONE):
  - Full quotient is N-1+Q bits.
  - If any bit above N-2 is set: `o_ovr`=1 and magnitude = all ones.
  - Otherwise magnitude = low N-1 bits, truncated toward zero.
  - Sign = XOR of the input signs, except a zero magnitude always gets sign 0 (no negative zero).
  - Operand registers are not modified.
- **DONE.** `o_done`=1 for one cycle, then unconditionally go to IDLE. A start pulse present in the DONE cycle is lost.
- **Reset mid-operation.** Immediate abort to IDLE. Outputs cleared as at reset. No done pulse.

## Timing
- Start sampled at edge E0. LOAD during cycle E0..E1.
- Normal path: RUN occupies edges E1..E(N-1+Q). DONE cycle follows E(N-1+Q), giving `o_done` high after E46 for defaults. Back in IDLE after E(N+Q), so the next start can be accepted at E(N+Q)+1 at the earliest.
- Divide-by-zero path: DONE follows E1, i.e. 2-cycle latency.
- `o_busy`: high from after E0 until DONE is entered; low during DONE.
- Results are valid in the DONE cycle and stable until the LOAD following the next accepted start.

## Structure
- **Shared package `qfix_pkg`.** Default N/Q constants (shared with the multiplier) and the state enum {IDLE, LOAD, RUN, DONE}.
- **Sub-module `qdiv_step`.** Purely combinational.
  - Inputs: remainder, divisor magnitude, incoming numerator bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside `qdiv`, which owns the FSM, counter and result registers.

## Test plan
- 3.0 / 2.0: 0x00018000 / 0x00010000 → `o_quotient`=0x0000C000, `o_ovr`=0, `o_done` exactly 46 cycles after LOAD.
- −1.5 / 0.5: 0x8000C000 / 0x00004000 → 0x80018000. 1/3: 0x00008000 / 0x00018000 → 0x00002AAA (truncated).
- Overflow: 0x7FFFFFFF / 0x00000001 → 0x7FFFFFFF, `o_ovr`=1, `o_div0`=0. Then 0x80000000 / 0x00008000 → 0x00000000 (no negative zero).
- Divide-by-zero: 0x80008000 / 0x80000000 → 0x7FFFFFFF with `o_div0`=1 and `o_ovr`=1; `o_done` in the second cycle after start.
- Start ignored while busy:
  - Pulse `i_start` with different operands mid-RUN → the first result is unchanged and only one `o_done` occurs.
  - Back-to-back operations → second result is correct.
- Asynchronous reset asserted mid-RUN (between edges) → outputs 0 immediately with no `o_done`. A fresh 3.0/2.0 after release completes correctly.
